// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake; single-cycle arithmetic/logic ops
// and multi-cycle bit-serial shifts, one bit position per clock.
module alu_pipe #(
  parameter int unsigned SIZEDATA = 8,
  parameter int unsigned SIZEOP   = 6
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [SIZEDATA-1:0] i_datoa,
  input  logic [SIZEDATA-1:0] i_datob,
  input  logic [SIZEOP-1:0]   i_opcode,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZEDATA-1:0] o_result,
  output logic                o_zero,
  output logic                o_negative,
  output logic                o_carry,
  output logic                o_overflow,
  output logic                o_error
);

  localparam int unsigned MSB = SIZEDATA - 1;
  localparam int unsigned CW  = $clog2(SIZEDATA + 1);

  localparam logic [SIZEOP-1:0] OP_ADD = SIZEOP'(6'b100000);
  localparam logic [SIZEOP-1:0] OP_SUB = SIZEOP'(6'b100010);
  localparam logic [SIZEOP-1:0] OP_AND = SIZEOP'(6'b100100);
  localparam logic [SIZEOP-1:0] OP_OR  = SIZEOP'(6'b100101);
  localparam logic [SIZEOP-1:0] OP_XOR = SIZEOP'(6'b100110);
  localparam logic [SIZEOP-1:0] OP_NOR = SIZEOP'(6'b100111);
  localparam logic [SIZEOP-1:0] OP_SRL = SIZEOP'(6'b000010);
  localparam logic [SIZEOP-1:0] OP_SRA = SIZEOP'(6'b000011);
  localparam logic [SIZEOP-1:0] OP_SLL = SIZEOP'(6'b000000);

  localparam logic [SIZEDATA-1:0] DMAX = SIZEDATA'(SIZEDATA);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, OUT = 2'd2} state_t;
  typedef enum logic [1:0] {SH_SLL = 2'b00, SH_SRL = 2'b10, SH_SRA = 2'b11} shkind_t;

  state_t              state, state_n;
  shkind_t             kind, kind_n;
  logic [SIZEDATA-1:0] result, result_n, sh, sh_n, step;
  logic [CW-1:0]       cnt, cnt_n, cnt_cap;
  logic                zero, zero_n, negative, negative_n;
  logic                carry, carry_n, overflow, overflow_n, error, error_n;
  logic                accept;
  logic [SIZEDATA:0]   sum, diff;
  logic                ld, ld_c, ld_v, ld_e;
  logic [SIZEDATA-1:0] ld_val;

  assign o_ready    = (state == IDLE) || ((state == OUT) && i_ready);
  assign o_valid    = (state == OUT);
  assign o_result   = result;
  assign o_zero     = zero;
  assign o_negative = negative;
  assign o_carry    = carry;
  assign o_overflow = overflow;
  assign o_error    = error;

  assign accept  = i_valid && o_ready;
  assign sum     = {1'b0, i_datoa} + {1'b0, i_datob};
  assign diff    = {1'b0, i_datoa} - {1'b0, i_datob};
  assign cnt_cap = (i_datob >= DMAX) ? CW'(SIZEDATA) : i_datob[CW-1:0];

  // One-bit shift step for the serial shifter
  always_comb begin
    step = {1'b0, sh[MSB:1]};
    case (kind)
      SH_SLL:  step = {sh[MSB-1:0], 1'b0};
      SH_SRA:  step = {sh[MSB], sh[MSB:1]};
      default: step = {1'b0, sh[MSB:1]};
    endcase
  end

  // Next-state, datapath and flag computation
  always_comb begin
    state_n    = state;
    kind_n     = kind;
    sh_n       = sh;
    cnt_n      = cnt;
    result_n   = result;
    zero_n     = zero;
    negative_n = negative;
    carry_n    = carry;
    overflow_n = overflow;
    error_n    = error;
    ld         = 1'b0;
    ld_val     = '0;
    ld_c       = 1'b0;
    ld_v       = 1'b0;
    ld_e       = 1'b0;

    case (state)
      IDLE, OUT: begin
        if (accept) begin
          state_n = OUT;
          ld      = 1'b1;
          case (i_opcode)
            OP_ADD: begin
              ld_val = sum[MSB:0];
              ld_c   = sum[SIZEDATA];
              ld_v   = (i_datoa[MSB] == i_datob[MSB]) && (sum[MSB] != i_datoa[MSB]);
            end
            OP_SUB: begin
              ld_val = diff[MSB:0];
              ld_c   = diff[SIZEDATA];
              ld_v   = (i_datoa[MSB] != i_datob[MSB]) && (diff[MSB] != i_datoa[MSB]);
            end
            OP_AND: ld_val = i_datoa & i_datob;
            OP_OR:  ld_val = i_datoa | i_datob;
            OP_XOR: ld_val = i_datoa ^ i_datob;
            OP_NOR: ld_val = ~(i_datoa | i_datob);
            OP_SRL, OP_SRA, OP_SLL: begin
              ld_val = i_datoa;
              if (cnt_cap != '0) begin
                ld      = 1'b0;
                state_n = SHIFT;
                sh_n    = i_datoa;
                cnt_n   = cnt_cap;
                kind_n  = shkind_t'(i_opcode[1:0]);
              end
            end
            default: begin
              ld_val = '0;
              ld_e   = 1'b1;
            end
          endcase
        end else if (state == OUT && i_ready) begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        sh_n  = step;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = OUT;
          ld      = 1'b1;
          ld_val  = step;
        end
      end
      default: state_n = IDLE;
    endcase

    if (ld) begin
      result_n   = ld_val;
      zero_n     = (ld_val == '0);
      negative_n = ld_val[MSB];
      carry_n    = ld_c;
      overflow_n = ld_v;
      error_n    = ld_e;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      kind     <= SH_SLL;
      sh       <= '0;
      cnt      <= '0;
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      kind     <= kind_n;
      sh       <= sh_n;
      cnt      <= cnt_n;
      result   <= result_n;
      zero     <= zero_n;
      negative <= negative_n;
      carry    <= carry_n;
      overflow <= overflow_n;
      error    <= error_n;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expected results queued on accept, compared
// on each consumed output; directed latency, hold, back-to-back and reset cases.
module tb_alu_pipe;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic [4:0]   flags;  // {zero, negative, carry, overflow, error}
  } exp_t;

  logic         i_clk = 1'b0;
  logic         i_reset, i_valid, i_ready;
  logic [W-1:0] i_datoa, i_datob;
  logic [5:0]   i_opcode;
  logic         o_ready, o_valid;
  logic [W-1:0] o_result;
  logic         o_zero, o_negative, o_carry, o_overflow, o_error;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  alu_pipe #(.SIZEDATA(W), .SIZEOP(6)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_datoa(i_datoa), .i_datob(i_datob), .i_opcode(i_opcode),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_zero(o_zero), .o_negative(o_negative), .o_carry(o_carry),
    .o_overflow(o_overflow), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   s, sa, sb_, bm;
    logic c, v, er;
    c = 1'b0; v = 1'b0; er = 1'b0;
    sa = int'($signed(a));
    sb_ = int'($signed(b));
    bm = (int'(b) >= int'(W)) ? int'(W) : int'(b);
    case (op)
      6'b100000: begin
        s = int'(a) + int'(b); e.res = W'(s); c = (s > 255);
        v = ((sa + sb_) > 127) || ((sa + sb_) < -128);
      end
      6'b100010: begin
        s = int'(a) - int'(b); e.res = W'(s); c = (a < b);
        v = ((sa - sb_) > 127) || ((sa - sb_) < -128);
      end
      6'b100100: e.res = a & b;
      6'b100101: e.res = a | b;
      6'b100110: e.res = a ^ b;
      6'b100111: e.res = ~(a | b);
      6'b000010: e.res = W'(int'(a) >> bm);
      6'b000011: e.res = W'(sa >>> bm);
      6'b000000: e.res = W'(int'(a) << bm);
      default: begin e.res = '0; er = 1'b1; end
    endcase
    e.flags = {(e.res == '0), e.res[W-1], c, v, er};
    return e;
  endfunction

  // Scoreboard: compare each result as it is consumed
  always @(negedge i_clk) begin
    if (!i_reset && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", o_result, e.res);
        check("sb_flags", {o_zero, o_negative, o_carry, o_overflow, o_error}, e.flags);
      end
    end
  end

  // Present an op and wait for acceptance; starts and ends just after a rising edge
  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waits);
    i_opcode = op; i_datoa = a; i_datob = b; i_valid = 1'b1; waits = 0;
    @(negedge i_clk);
    while (!o_ready && waits < 100) begin
      waits++;
      @(negedge i_clk);
    end
    if (!o_ready) check("accept_timeout", 0, 1);
    else sb.push_back(model(op, a, b));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  // Cycles from accept edge until o_valid, checking o_ready low while busy
  task automatic measure(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (lat < 50) begin
      @(negedge i_clk);
      if (o_valid) break;
      check({tag, "_busy_ready"}, o_ready, 0);
      @(posedge i_clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    @(posedge i_clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [5:0] ops [10];
    ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
            6'b100111, 6'b000010, 6'b000011, 6'b000000, 6'b010101};

    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_datoa = '0; i_datob = '0; i_opcode = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_flags", {o_zero, o_negative, o_carry, o_overflow, o_error}, 0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("rst_ready", o_ready, 1);
    @(posedge i_clk); #1;

    // Arithmetic corner cases
    issue(6'b100000, 8'h7F, 8'h01, w); measure("add_ovf", 1);
    issue(6'b100010, 8'h00, 8'h01, w); measure("sub_borrow", 1);
    issue(6'b100000, 8'hFF, 8'h01, w); measure("add_carry", 1);
    issue(6'b100111, 8'h0F, 8'hF0, w); measure("nor", 1);

    // Shift latency and clamp
    issue(6'b000011, 8'h80, 8'd3, w);   measure("sra3", 4);
    issue(6'b000010, 8'h80, 8'd200, w); measure("srl200", 9);
    issue(6'b000000, 8'hA5, 8'd0, w);   measure("sll0", 1);
    issue(6'b000011, 8'h81, 8'd9, w);   measure("sra9", 9);

    // Illegal opcode
    issue(6'b111111, 8'h12, 8'h34, w); measure("illegal", 1);

    // Hold in OUT with i_ready low
    i_ready = 1'b0;
    issue(6'b100000, 8'h10, 8'h20, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("hold_valid", o_valid, 1);
      check("hold_ready", o_ready, 0);
      check("hold_result", o_result, 8'h30);
      check("hold_flags", {o_zero, o_negative, o_carry, o_overflow, o_error}, 5'b00000);
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;

    // Back-to-back single-cycle ops: accepted each cycle, results with no gaps
    for (int k = 0; k < 4; k++) begin
      issue(6'b100000, W'(8'h11 * k), 8'h05, w);
      check("b2b_wait", w, 0);
      check("b2b_valid", o_valid, 1);
    end
    @(posedge i_clk); #1;

    // Reset mid-shift discards the operation
    issue(6'b000010, 8'h80, 8'd5, w);
    repeat (2) begin @(posedge i_clk); #1; end
    i_reset = 1'b1;
    sb.delete();
    @(posedge i_clk); #1;
    check("rstshift_valid", o_valid, 0);
    check("rstshift_result", o_result, 0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("rstshift_ready", o_ready, 1);
    @(posedge i_clk); #1;

    // Random mix
    for (int k = 0; k < 60; k++) begin
      logic [5:0]   op;
      logic [W-1:0] a, b;
      op = ops[$urandom_range(0, 9)];
      a  = W'($urandom_range(0, 255));
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 9));
      issue(op, a, b, w);
    end
    repeat (20) @(posedge i_clk);
    #1;
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter SIZEDATA, default 8, operand/result width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter SIZEOP, default 6, opcode width in bits (fixed encoding below, 6 only).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high, with ports named i_clk and i_reset.
REQ-004 i_clk  input  1  rising-edge clock for all state.
REQ-005 i_reset  input  1  synchronous active-high reset.
REQ-006 i_valid  input  1  operands/opcode presented.
REQ-007 o_ready  output  1  block accepts an operation this cycle.
REQ-008 i_datoa  input  SIZEDATA  operand A, signed two's complement.
REQ-009 i_datob  input  SIZEDATA  operand B; unsigned shift amount for shift ops.
REQ-010 i_opcode  input  SIZEOP  operation select.
REQ-011 o_valid  output  1  result and flags valid.
REQ-012 i_ready  input  1  downstream consumes the result.
REQ-013 o_result  output  SIZEDATA  registered result.
REQ-014 o_zero, o_negative, o_carry, o_overflow, o_error  output  1 each  registered flags.

Function
REQ-015 Opcodes SHALL be: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011, SLL 000000; any other code is illegal.
REQ-016 FSM states SHALL be IDLE, SHIFT, OUT.
REQ-017 o_ready SHALL be 1 in IDLE, 1 in OUT when i_ready=1, else 0; an operation is accepted when i_valid & o_ready.
REQ-018 ADD/SUB/logic ops and illegal opcodes SHALL complete in one cycle: accept in cycle N -> OUT with o_valid=1 in cycle N+1.
REQ-019 Shift ops SHALL capture A and count = min(B unsigned, SIZEDATA); count 0 -> OUT next cycle with result=A; else -> SHIFT.
REQ-020 In SHIFT one bit position SHALL shift per cycle and count decrement; transition to OUT on the final shift; o_valid rises count+1 cycles after accept.
REQ-021 SRL/SLL SHALL fill with zeros, SRA with A[MSB]; count clamp gives 0 (SRL/SLL) or all sign bits (SRA) for B >= SIZEDATA.
REQ-022 In OUT: i_ready=0 -> hold o_result and all flags stable; i_ready=1 & i_valid=1 -> accept new op same cycle (back-to-back, throughput 1/cycle for single-cycle ops); i_ready=1 & i_valid=0 -> IDLE with o_valid=0.
REQ-023 o_valid SHALL be 1 only in OUT; inputs SHALL be ignored in SHIFT.
REQ-024 ADD/SUB SHALL be computed SIZEDATA+1 wide; o_carry = ADD carry-out or SUB borrow (1 iff A < B unsigned).
REQ-025 o_overflow SHALL flag signed overflow for ADD/SUB (operand signs equal for ADD / differ for SUB, result sign differs from A).
REQ-026 o_carry and o_overflow SHALL be 0 for logic, shift and illegal ops.
REQ-027 o_zero = (o_result == 0), o_negative = o_result[SIZEDATA-1], for every op.
REQ-028 Illegal opcode SHALL give o_result=0, o_zero=1, o_error=1; o_error SHALL be 0 for legal ops.

Reset
REQ-029 When i_reset=1 at a clock edge, state SHALL go IDLE and o_valid, o_result, all flags and the shift count SHALL go 0, overriding any other event.
REQ-030 Reset in SHIFT or OUT SHALL discard the operation in flight; o_ready=1 in the first cycle after reset deasserts.
REQ-031 No operation SHALL be accepted in a cycle where i_reset=1.

Verification (SIZEDATA=8)
REQ-032 ADD A=0x7F B=0x01, i_ready=1 -> next cycle o_valid=1, result 0x80, overflow=1, negative=1, carry=0, zero=0.
REQ-033 SUB A=0x00 B=0x01 -> result 0xFF, carry=1, negative=1, overflow=0; ADD 0xFF+0x01 -> 0x00, zero=1, carry=1.
REQ-034 SRA A=0x80 B=3 -> o_ready=0 for 3 cycles, o_valid 4 cycles after accept, result 0xF0; SRL A=0x80 B=200 -> result 0x00, zero=1, o_valid 9 cycles after accept.
REQ-035 Hold i_ready=0 3 cycles in OUT -> result/flags unchanged, o_ready=0; then 4 back-to-back ADDs with i_ready=1 -> 4 results on consecutive cycles, no bubbles.
REQ-036 Reset asserted mid-SHIFT -> o_valid=0, result 0 next cycle, o_ready=1 after release; opcode 111111 -> result 0, error=1, zero=1.
